alu_seq_unit: RTL



---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_muldiv_iter.sv | 57 +++++
 rtl/alu_seq_unit.sv | 134 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared declarations for the sequenced ALU: opcodes, controller states, flag layout.
package alu_pkg;

  // Codes 1 and 2 are the retired operand-read ops, kept so encodings stay stable.
  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_RD1 = 4'd1,
    OP_RD2 = 4'd2,
    OP_ADD = 4'd3,
    OP_SUB = 4'd4,
    OP_SHR = 4'd5,
    OP_SHL = 4'd6,
    OP_AND = 4'd7,
    OP_OR  = 4'd8,
    OP_NEG = 4'd9,
    OP_MUL = 4'd10,
    OP_DIV = 4'd11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ITER,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic err;
    logic ovf;
    logic carry;
    logic zero;
  } flags_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Bit-serial multiply (shift-add) / restoring divide datapath sharing one 2*WIDTH register.
module alu_muldiv_iter #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             load,
  input  logic             step,
  input  logic             mode,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             last,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0]   opr;
  logic [SHW-1:0]     cnt;
  logic [WIDTH:0]     add_s, rem_sh, diff;

  // mode=0: lower half holds the multiplier and shifts out as the product shifts in.
  // mode=1: upper half is the partial remainder, lower half collects quotient bits.
  always_comb begin
    add_s  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opr} : '0);
    rem_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff   = rem_sh - {1'b0, opr};
    if (!mode)
      acc_nxt = {add_s, acc[WIDTH-1:1]};
    else if (!diff[WIDTH])
      acc_nxt = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else
      acc_nxt = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
  end

  // Outputs are the post-step value so the final step can be registered directly.
  assign last = (cnt == SHW'(WIDTH - 1));
  assign hi   = acc_nxt[2*WIDTH-1:WIDTH];
  assign lo   = acc_nxt[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      acc <= '0;
      opr <= '0;
      cnt <= '0;
    end else if (load) begin
      acc <= {{WIDTH{1'b0}}, opa};
      opr <= opb;
      cnt <= '0;
    end else if (step) begin
      acc <= acc_nxt;
      if (!last) cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/alu_seq_unit.sv
// Handshaked ALU: single-cycle ops complete directly, MUL/DIV iterate one bit per cycle.
module alu_seq_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       flags
);

  localparam int SHW = $clog2(WIDTH);

  state_e           state, state_nxt;
  logic             is_div_q, load, step, it_last, iter_c;
  logic [WIDTH-1:0] it_hi, it_lo, res_c, hi_c, res_q, hi_q;
  logic [WIDTH:0]   sum, dif;
  flags_t           flg_c, flg_it, flg_q;

  alu_muldiv_iter #(.WIDTH(WIDTH), .SHW(SHW)) u_iter (
    .clk   (clk),
    .rst_b (rst_b),
    .load  (load),
    .step  (step),
    .mode  (is_div_q),
    .opa   (opa),
    .opb   (opb),
    .last  (it_last),
    .hi    (it_hi),
    .lo    (it_lo)
  );

  always_comb begin
    sum    = {1'b0, opa} + {1'b0, opb};
    dif    = {1'b0, opa} - {1'b0, opb};
    res_c  = '0;
    hi_c   = '0;
    flg_c  = '0;
    iter_c = 1'b0;
    case (opcode)
      OP_NOP: ;
      OP_ADD: begin
        res_c       = sum[WIDTH-1:0];
        flg_c.carry = sum[WIDTH];
        flg_c.ovf   = (opa[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != opa[WIDTH-1]);
      end
      OP_SUB: begin
        res_c       = dif[WIDTH-1:0];
        flg_c.carry = dif[WIDTH];
        flg_c.ovf   = (opa[WIDTH-1] != opb[WIDTH-1]) && (dif[WIDTH-1] != opa[WIDTH-1]);
      end
      OP_SHR: res_c = opa >> opb[SHW-1:0];
      OP_SHL: res_c = opa << opb[SHW-1:0];
      OP_AND: res_c = opa & opb;
      OP_OR:  res_c = opa | opb;
      OP_NEG: res_c = ~opa;
      OP_MUL: iter_c = 1'b1;
      OP_DIV: begin
        if (opb == '0) begin
          res_c     = '1;
          hi_c      = opa;
          flg_c.err = 1'b1;
        end else begin
          iter_c = 1'b1;
        end
      end
      default: flg_c.err = 1'b1;
    endcase
    // Illegal codes leave res_c at 0, which yields their required zero=1.
    flg_c.zero = (res_c == '0);
  end

  always_comb begin
    flg_it       = '0;
    flg_it.ovf   = !is_div_q && (it_hi != '0);
    flg_it.zero  = (it_lo == '0);
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      ST_IDLE: if (in_valid) begin
        load      = iter_c;
        state_nxt = iter_c ? ST_ITER : ST_DONE;
      end
      ST_ITER: begin
        step = 1'b1;
        if (it_last) state_nxt = ST_DONE;
      end
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state    <= ST_IDLE;
      is_div_q <= 1'b0;
      res_q    <= '0;
      hi_q     <= '0;
      flg_q    <= '0;
    end else begin
      state <= state_nxt;
      if (load) is_div_q <= (opcode == OP_DIV);
      if (state == ST_IDLE && in_valid && !iter_c) begin
        res_q <= res_c;
        hi_q  <= hi_c;
        flg_q <= flg_c;
      end else if (state == ST_ITER && it_last) begin
        res_q <= it_lo;
        hi_q  <= it_hi;
        flg_q <= flg_it;
      end
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign result    = res_q;
  assign result_hi = hi_q;
  assign flags     = flg_q;

endmodule
